decode_rf_stage: RTL

Parametrised decode / register-read pipeline stage for the 16-bit pipelined CPU, sitting between IF and EX. It decodes the instruction, drives register-file read addresses, and selects each operand from the forwarding network. It detects load-use hazards and inserts bubbles. The ID/EX register advances under a valid/ready handshake with stall and flush.

---
 rtl/decode_rf_stage_if.sv | 62 ++++++
 rtl/decode_rf_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/decode_rf_stage_if.sv
// rtl/decode_rf_stage_if.sv - IF/ID input, RF read, forwarding and ID/EX output bundle
interface decode_rf_stage_if #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16
);
  // IF/ID side
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [15:0]       in_instr;
  // register file read port
  logic [2:0]        rf_rx_addr;
  logic [2:0]        rf_ry_addr;
  logic [DATA_W-1:0] rf_rx_data;
  logic [DATA_W-1:0] rf_ry_data;
  // forwarding network
  logic              ex_wr_en;
  logic              ex_is_load;
  logic [2:0]        ex_wr_addr;
  logic [DATA_W-1:0] ex_wr_data;
  logic              wb_wr_en;
  logic [2:0]        wb_wr_addr;
  logic [DATA_W-1:0] wb_wr_data;
  // ID/EX side
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [15:0]       out_instr;
  logic [DATA_W-1:0] out_opa;
  logic [DATA_W-1:0] out_opb;
  logic [DATA_W-1:0] out_imm;
  logic [2:0]        out_alu_op;
  logic              out_wr_en;
  logic              out_is_load;
  logic              out_is_store;
  logic              out_is_branch;
  logic              out_use_imm;
  logic [2:0]        out_wr_addr;

  modport slave (
    input  flush, in_valid, in_pc, in_instr,
    input  rf_rx_data, rf_ry_data,
    input  ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
    input  wb_wr_en, wb_wr_addr, wb_wr_data,
    input  out_ready,
    output in_ready, rf_rx_addr, rf_ry_addr,
    output out_valid, out_pc, out_instr, out_opa, out_opb, out_imm, out_alu_op,
    output out_wr_en, out_is_load, out_is_store, out_is_branch, out_use_imm, out_wr_addr
  );

  modport master (
    output flush, in_valid, in_pc, in_instr,
    output rf_rx_data, rf_ry_data,
    output ex_wr_en, ex_is_load, ex_wr_addr, ex_wr_data,
    output wb_wr_en, wb_wr_addr, wb_wr_data,
    output out_ready,
    input  in_ready, rf_rx_addr, rf_ry_addr,
    input  out_valid, out_pc, out_instr, out_opa, out_opb, out_imm, out_alu_op,
    input  out_wr_en, out_is_load, out_is_store, out_is_branch, out_use_imm, out_wr_addr
  );
endinterface

// File: rtl/decode_rf_stage.sv
// rtl/decode_rf_stage.sv - decode / register-read stage with forwarding, load-use stall and ID/EX register
module decode_rf_stage #(
  parameter int DATA_W = 16,
  parameter int PC_W   = 16,
  parameter bit FWD_EN = 1'b1
) (
  input logic                clk,
  input logic                reset_n,
  decode_rf_stage_if.slave   bus
);

  localparam logic [4:0] OP_MV    = 5'b0_0000;
  localparam logic [4:0] OP_ADD   = 5'b0_0001;
  localparam logic [4:0] OP_SUB   = 5'b0_0010;
  localparam logic [4:0] OP_CMP   = 5'b0_0011;
  localparam logic [4:0] OP_LD    = 5'b0_0100;
  localparam logic [4:0] OP_ST    = 5'b0_0101;
  localparam logic [4:0] OP_JR    = 5'b0_1000;
  localparam logic [4:0] OP_JZR   = 5'b0_1001;
  localparam logic [4:0] OP_JNR   = 5'b0_1010;
  localparam logic [4:0] OP_CALLR = 5'b0_1100;
  localparam logic [4:0] OP_MVI   = 5'b1_0000;
  localparam logic [4:0] OP_ADDI  = 5'b1_0001;
  localparam logic [4:0] OP_SUBI  = 5'b1_0010;
  localparam logic [4:0] OP_CMPI  = 5'b1_0011;
  localparam logic [4:0] OP_MVHI  = 5'b1_0110;
  localparam logic [4:0] OP_J     = 5'b1_1000;
  localparam logic [4:0] OP_JZ    = 5'b1_1001;
  localparam logic [4:0] OP_JN    = 5'b1_1010;
  localparam logic [4:0] OP_CALL  = 5'b1_1100;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_MVHI = 3'b010;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [15:0]       instr;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] imm;
    logic [2:0]        alu_op;
    logic              wr_en;
    logic [2:0]        wr_addr;
    logic              is_load;
    logic              is_store;
    logic              is_branch;
    logic              use_imm;
  } payload_t;

  logic [4:0]        opc;
  logic [2:0]        rx, ry;
  logic [DATA_W-1:0] imm_s8, imm_hi, imm_s11;

  logic              use_rx, use_ry, wr_en, wr_r7;
  logic              is_load, is_store, is_branch, use_imm;
  logic [2:0]        alu_op;
  logic [DATA_W-1:0] imm;

  logic              ex_hit_rx, ex_hit_ry, wb_hit_rx, wb_hit_ry;
  logic              stall_rx, stall_ry, hazard, advance;
  logic [DATA_W-1:0] opa, opb;

  payload_t          pl_new, pl_d, pl_q;
  logic              valid_d, valid_q;

  assign opc = bus.in_instr[4:0];
  assign rx  = bus.in_instr[7:5];
  assign ry  = bus.in_instr[10:8];

  assign bus.rf_rx_addr = rx;
  assign bus.rf_ry_addr = ry;

  assign imm_s8  = {{(DATA_W-8){bus.in_instr[15]}}, bus.in_instr[15:8]};
  assign imm_hi  = {bus.in_instr[15:8], {(DATA_W-8){1'b0}}};
  assign imm_s11 = {{(DATA_W-12){bus.in_instr[15]}}, bus.in_instr[15:5], 1'b0};

  // Instruction decode: source use, write target, class flags, ALU op and immediate
  always_comb begin
    use_rx    = 1'b0;
    use_ry    = 1'b0;
    wr_en     = 1'b0;
    wr_r7     = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    use_imm   = 1'b0;
    alu_op    = ALU_ADD;
    imm       = '0;
    case (opc)
      OP_MV:    begin use_ry = 1'b1; wr_en = 1'b1; end
      OP_ADD:   begin use_rx = 1'b1; use_ry = 1'b1; wr_en = 1'b1; end
      OP_SUB:   begin use_rx = 1'b1; use_ry = 1'b1; wr_en = 1'b1; alu_op = ALU_SUB; end
      OP_CMP:   begin use_rx = 1'b1; use_ry = 1'b1; alu_op = ALU_SUB; end
      OP_LD:    begin use_ry = 1'b1; wr_en = 1'b1; is_load = 1'b1; end
      OP_ST:    begin use_rx = 1'b1; use_ry = 1'b1; is_store = 1'b1; end
      OP_JR, OP_JZR, OP_JNR: begin use_rx = 1'b1; is_branch = 1'b1; end
      OP_CALLR: begin use_rx = 1'b1; is_branch = 1'b1; wr_en = 1'b1; wr_r7 = 1'b1; end
      OP_MVI:   begin wr_en = 1'b1; use_imm = 1'b1; imm = imm_s8; end
      OP_ADDI:  begin use_rx = 1'b1; wr_en = 1'b1; use_imm = 1'b1; imm = imm_s8; end
      OP_SUBI:  begin use_rx = 1'b1; wr_en = 1'b1; use_imm = 1'b1; imm = imm_s8; alu_op = ALU_SUB; end
      OP_CMPI:  begin use_rx = 1'b1; use_imm = 1'b1; imm = imm_s8; alu_op = ALU_SUB; end
      OP_MVHI:  begin use_rx = 1'b1; wr_en = 1'b1; use_imm = 1'b1; imm = imm_hi; alu_op = ALU_MVHI; end
      OP_J, OP_JZ, OP_JN: begin is_branch = 1'b1; use_imm = 1'b1; imm = imm_s11; end
      OP_CALL:  begin is_branch = 1'b1; use_imm = 1'b1; imm = imm_s11; wr_en = 1'b1; wr_r7 = 1'b1; end
      default:  ;
    endcase
  end

  assign ex_hit_rx = bus.ex_wr_en && (bus.ex_wr_addr == rx);
  assign ex_hit_ry = bus.ex_wr_en && (bus.ex_wr_addr == ry);
  assign wb_hit_rx = bus.wb_wr_en && (bus.wb_wr_addr == rx);
  assign wb_hit_ry = bus.wb_wr_en && (bus.wb_wr_addr == ry);

  // A load in EX has no data yet; without forwarding any in-flight writer must drain first
  assign stall_rx = use_rx & ((ex_hit_rx & bus.ex_is_load) | (!FWD_EN & (ex_hit_rx | wb_hit_rx)));
  assign stall_ry = use_ry & ((ex_hit_ry & bus.ex_is_load) | (!FWD_EN & (ex_hit_ry | wb_hit_ry)));
  assign hazard   = stall_rx | stall_ry;

  assign advance      = !valid_q | bus.out_ready;
  assign bus.in_ready = bus.flush | (advance & !hazard);

  // Operand select: youngest non-load EX result, then WB, then register file
  always_comb begin
    opa = bus.rf_rx_data;
    opb = bus.rf_ry_data;
    if (FWD_EN) begin
      if (ex_hit_rx && !bus.ex_is_load) opa = bus.ex_wr_data;
      else if (wb_hit_rx)               opa = bus.wb_wr_data;
      if (ex_hit_ry && !bus.ex_is_load) opb = bus.ex_wr_data;
      else if (wb_hit_ry)               opb = bus.wb_wr_data;
    end
  end

  assign pl_new = '{
    pc:        bus.in_pc,
    instr:     bus.in_instr,
    opa:       opa,
    opb:       opb,
    imm:       imm,
    alu_op:    alu_op,
    wr_en:     wr_en,
    wr_addr:   wr_r7 ? 3'd7 : (wr_en ? rx : 3'd0),
    is_load:   is_load,
    is_store:  is_store,
    is_branch: is_branch,
    use_imm:   use_imm
  };

  // ID/EX next state: flush beats everything, then issue, then bubble, else hold
  always_comb begin
    valid_d = valid_q;
    pl_d    = pl_q;
    if (bus.flush) begin
      valid_d = 1'b0;
    end else if (advance && bus.in_valid && !hazard) begin
      valid_d = 1'b1;
      pl_d    = pl_new;
    end else if (advance) begin
      valid_d = 1'b0;
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      pl_q    <= '0;
    end else begin
      valid_q <= valid_d;
      pl_q    <= pl_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_pc        = pl_q.pc;
  assign bus.out_instr     = pl_q.instr;
  assign bus.out_opa       = pl_q.opa;
  assign bus.out_opb       = pl_q.opb;
  assign bus.out_imm       = pl_q.imm;
  assign bus.out_alu_op    = pl_q.alu_op;
  assign bus.out_wr_en     = pl_q.wr_en;
  assign bus.out_wr_addr   = pl_q.wr_addr;
  assign bus.out_is_load   = pl_q.is_load;
  assign bus.out_is_store  = pl_q.is_store;
  assign bus.out_is_branch = pl_q.is_branch;
  assign bus.out_use_imm   = pl_q.use_imm;

endmodule
